// File: rtl/gpu_text_engine_if.sv
// CPU command channel plus display read port of the text engine.
interface gpu_text_engine_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 12
);
  logic [15:0]   cpuline;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;

  modport master (
    output cpuline, cmd_valid, disp_addr,
    input  cmd_ready, disp_data
  );

  modport slave (
    input  cpuline, cmd_valid, disp_addr,
    output cmd_ready, disp_data
  );
endinterface

// File: rtl/gpu_text_engine.sv
// Text-mode command engine: two-word CPU packets drive a COLS x ROWS {attr,char}
// buffer with cursor tracking, multi-cycle clear and scroll, and a display read port.
module gpu_text_engine #(
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 25,
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned ATTR_W    = 4,
  parameter int unsigned SCROLL_EN = 1,
  parameter int unsigned AW        = $clog2(COLS*ROWS),
  parameter int unsigned XW        = $clog2(COLS),
  parameter int unsigned YW        = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                clr,
  gpu_text_engine_if.slave    bus,
  output logic                busy,
  output logic [XW-1:0]       cursor_x,
  output logic [YW-1:0]       cursor_y
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned M  = COLS * (ROWS - 1);
  localparam int unsigned DW = CHAR_W + ATTR_W;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [15:0] OP_CLR   = 16'h00C0;
  localparam logic [15:0] OP_PUT   = 16'h00C1;
  localparam logic [15:0] OP_BS    = 16'h00C2;
  localparam logic [15:0] OP_SETY  = 16'h00C3;
  localparam logic [15:0] OP_SETX  = 16'h00C4;
  localparam logic [15:0] OP_CLR2  = 16'h00C5;
  localparam logic [15:0] OP_NL    = 16'h00C6;
  localparam logic [15:0] OP_ATTR  = 16'h00C7;

  localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
  localparam logic [15:0]   COLS_P   = 16'(COLS);
  localparam logic [15:0]   ROWS_P   = 16'(ROWS);
  localparam logic [AW:0]   N_A      = (AW+1)'(N);
  localparam logic [CW-1:0] CNT_CLR  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_COPY = CW'(M);
  localparam logic [CW-1:0] CNT_END  = CW'(N);

  typedef enum logic [2:0] {GET_OP, GET_PARAM, EXEC, CLEAR, SCROLL} state_e;

  state_e          state_q, state_d;
  logic [15:0]     op_q, op_d;
  logic [15:0]     param_q, param_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [ATTR_W-1:0] attr_q, attr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   disp_q, disp_d;

  logic [DW-1:0]   mem [N];
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            row_adv;
  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   scroll_raddr;
  logic [DW-1:0]   blank;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(AW'(y) * AW'(COLS)) + AW'(x);
  endfunction

  assign cur_addr     = addr_of(x_q, y_q);
  assign scroll_raddr = AW'(cnt_q) + AW'(COLS);
  assign blank        = {attr_q, {CHAR_W{1'b0}}};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    param_d = param_q;
    x_d     = x_q;
    y_d     = y_q;
    attr_d  = attr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    row_adv = 1'b0;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = blank;
    case (state_q)
      GET_OP: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cpuline;
          state_d = GET_PARAM;
        end
      end
      GET_PARAM: begin
        if (bus.cmd_valid) begin
          param_d = bus.cpuline;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = GET_OP;
        case (op_q)
          OP_CLR, OP_CLR2: begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
          OP_PUT: begin
            we    = 1'b1;
            wdata = {attr_q, param_q[CHAR_W-1:0]};
            if (x_q != X_MAX) x_d = x_q + XW'(1);
            else              row_adv = 1'b1;
          end
          OP_BS: begin
            if (x_q != '0 || y_q != '0) begin
              if (x_q != '0) begin
                x_d = x_q - XW'(1);
              end else begin
                x_d = X_MAX;
                y_d = y_q - YW'(1);
              end
              we    = 1'b1;
              waddr = addr_of(x_d, y_d);
            end
          end
          OP_SETY: y_d    = (param_q >= ROWS_P) ? Y_MAX : param_q[YW-1:0];
          OP_SETX: x_d    = (param_q >= COLS_P) ? X_MAX : param_q[XW-1:0];
          OP_NL:   row_adv = 1'b1;
          OP_ATTR: attr_d = param_q[ATTR_W-1:0];
          default: ;
        endcase
        if (row_adv) begin
          x_d = '0;
          if (y_q != Y_MAX) begin
            y_d = y_q + YW'(1);
          end else if (SCROLL_EN != 0) begin
            state_d = SCROLL;
            cnt_d   = '0;
          end else begin
            y_d = '0;
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = AW'(cnt_q);
        if (cnt_q == CNT_CLR) begin
          state_d = GET_OP;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCROLL: begin
        // Read cell cnt+COLS now, write it to cnt-1 next cycle; past the copy
        // region the same write slot blanks the last row.
        if (cnt_q < CNT_COPY) rd_d = mem[scroll_raddr];
        if (cnt_q != '0) begin
          we    = 1'b1;
          waddr = AW'(cnt_q - CW'(1));
          wdata = (cnt_q <= CNT_COPY) ? rd_q : blank;
        end
        if (cnt_q == CNT_END) state_d = GET_OP;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = GET_OP;
    endcase
  end

  always_comb begin
    disp_d = '0;
    if ({1'b0, bus.disp_addr} < N_A) disp_d = mem[bus.disp_addr];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= GET_OP;
      op_q    <= '0;
      param_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      attr_q  <= '1;
      cnt_q   <= '0;
      rd_q    <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      param_q <= param_d;
      x_q     <= x_d;
      y_q     <= y_d;
      attr_q  <= attr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.cmd_ready = (state_q == GET_OP) || (state_q == GET_PARAM);
  assign bus.disp_data = disp_q;
  assign busy          = (state_q == CLEAR) || (state_q == SCROLL);
  assign cursor_x      = x_q;
  assign cursor_y      = y_q;

endmodule

// File: tb/tb_gpu_text_engine.sv
// Bench for gpu_text_engine: table vectors, directed corner sequences and random
// commands checked against a cell-array reference model.
module tb_gpu_text_engine;
  localparam int unsigned COLS = 40;
  localparam int unsigned ROWS = 25;
  localparam int unsigned N    = COLS * ROWS;
  localparam int unsigned M    = COLS * (ROWS - 1);
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 12;
  localparam int          TMO  = 3000;

  logic clk = 1'b0;
  logic clr_a, clr_b;
  always #5 clk = ~clk;

  gpu_text_engine_if #(.AW(AW), .DW(DW)) ifa ();
  gpu_text_engine_if #(.AW(AW), .DW(DW)) ifb ();

  logic       busy_a, busy_b;
  logic [5:0] cx_a, cx_b;
  logic [4:0] cy_a, cy_b;

  gpu_text_engine #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(8), .ATTR_W(4), .SCROLL_EN(1)) dut_a (
    .clk(clk), .clr(clr_a), .bus(ifa.slave), .busy(busy_a), .cursor_x(cx_a), .cursor_y(cy_a));

  gpu_text_engine #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(8), .ATTR_W(4), .SCROLL_EN(0)) dut_b (
    .clk(clk), .clr(clr_b), .bus(ifb.slave), .busy(busy_b), .cursor_x(cx_b), .cursor_y(cy_b));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of dut_a
  logic [11:0] mmem [N];
  int          mx, my;
  logic [3:0]  mattr;

  typedef struct {
    logic [15:0] op;
    logic [15:0] prm;
    int          ex;
    int          ey;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles", nm, TMO);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.cmd_ready : ifb.cmd_ready;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [15:0] w);
    if (sel == 0) begin ifa.cmd_valid = v; ifa.cpuline = w; end
    else          begin ifb.cmd_valid = v; ifb.cpuline = w; end
  endtask

  task automatic send_word(input int sel, input logic [15:0] w);
    int t;
    t = 0;
    @(negedge clk);
    drive(sel, 1'b1, w);
    while (rdy(sel) !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout_fail("handshake");
    @(posedge clk);
    #1;
    drive(sel, 1'b0, w);
  endtask

  // Counts busy cycles until the engine is ready again; optionally keeps junk
  // on the bus with cmd_valid high while the engine is not accepting.
  task automatic wait_idle(input int sel, input bit hold, output int bc, output int re);
    int t;
    bc = 0; re = 0; t = 0;
    while (t < TMO) begin
      @(negedge clk);
      if (bsy(sel) === 1'b1 && rdy(sel) === 1'b1) re++;
      if (rdy(sel) === 1'b1) begin
        drive(sel, 1'b0, 16'h0000);
        break;
      end
      if (bsy(sel) === 1'b1) bc++;
      if (hold) drive(sel, 1'b1, 16'($urandom));
      t++;
    end
    if (t >= TMO) begin
      drive(sel, 1'b0, 16'h0000);
      timeout_fail("wait_idle");
    end
  endtask

  task automatic do_cmd(input int sel, input logic [15:0] op, input logic [15:0] prm,
                        input bit hold, output int bc, output int re);
    send_word(sel, op);
    send_word(sel, prm);
    wait_idle(sel, hold, bc, re);
  endtask

  task automatic rd(input int sel, input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    if (sel == 0) ifa.disp_addr = a; else ifb.disp_addr = a;
    @(posedge clk);
    #1;
    d = (sel == 0) ? ifa.disp_data : ifb.disp_data;
  endtask

  task automatic model_cmd(input logic [15:0] op, input logic [15:0] prm, output int eb);
    bit row_adv;
    eb = 0;
    row_adv = 0;
    case (op)
      16'h00C0, 16'h00C5: begin
        for (int i = 0; i < N; i++) mmem[i] = {mattr, 8'h00};
        mx = 0; my = 0; eb = N;
      end
      16'h00C1: begin
        mmem[my*COLS + mx] = {mattr, prm[7:0]};
        if (mx < COLS - 1) mx++; else row_adv = 1;
      end
      16'h00C2: begin
        if (mx != 0 || my != 0) begin
          if (mx > 0) mx--; else begin mx = COLS - 1; my--; end
          mmem[my*COLS + mx] = {mattr, 8'h00};
        end
      end
      16'h00C3: my = (int'(prm) >= ROWS) ? ROWS - 1 : int'(prm);
      16'h00C4: mx = (int'(prm) >= COLS) ? COLS - 1 : int'(prm);
      16'h00C6: row_adv = 1;
      16'h00C7: mattr = prm[3:0];
      default: ;
    endcase
    if (row_adv) begin
      mx = 0;
      if (my < ROWS - 1) my++;
      else begin
        for (int i = 0; i < M; i++) mmem[i] = mmem[i + COLS];
        for (int i = M; i < N; i++) mmem[i] = {mattr, 8'h00};
        eb = N + 1;
      end
    end
  endtask

  task automatic run_a(input logic [15:0] op, input logic [15:0] prm, input bit hold, input string nm);
    int bc, re, eb;
    do_cmd(0, op, prm, hold, bc, re);
    model_cmd(op, prm, eb);
    check({nm, "_busy"}, bc, eb);
    check({nm, "_rdy"}, re, 0);
    check({nm, "_x"}, cx_a, mx);
    check({nm, "_y"}, cy_a, my);
  endtask

  task automatic full_compare(input string nm);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      rd(0, AW'(i), d);
      check($sformatf("%s_cell%0d", nm, i), d, mmem[i]);
    end
  endtask

  initial begin : main
    vec_t vt[18];
    logic [DW-1:0] d;
    logic [15:0] op, prm;
    int bc, re, r;

    vt[0]  = '{16'h00C7, 16'h0003, 0, 0};
    vt[1]  = '{16'h00C1, 16'h0041, 1, 0};
    vt[2]  = '{16'h00C4, 16'd39, 39, 0};
    vt[3]  = '{16'h00C1, 16'h005A, 0, 1};
    vt[4]  = '{16'h00C2, 16'h0000, 39, 0};
    vt[5]  = '{16'h00C3, 16'd30, 39, 24};
    vt[6]  = '{16'h00C4, 16'd100, 39, 24};
    vt[7]  = '{16'h00C4, 16'd5, 5, 24};
    vt[8]  = '{16'h00C3, 16'd2, 5, 2};
    vt[9]  = '{16'h00C6, 16'h0000, 0, 3};
    vt[10] = '{16'h1234, 16'hFFFF, 0, 3};
    vt[11] = '{16'h00C2, 16'h0000, 39, 2};
    vt[12] = '{16'h00C3, 16'd24, 39, 24};
    vt[13] = '{16'h00C4, 16'd39, 39, 24};
    vt[14] = '{16'h00C3, 16'd0, 39, 0};
    vt[15] = '{16'h00C2, 16'h0000, 38, 0};
    vt[16] = '{16'h00C4, 16'd0, 0, 0};
    vt[17] = '{16'h00C2, 16'h0000, 0, 0};

    ifa.cmd_valid = 0; ifa.cpuline = '0; ifa.disp_addr = '0;
    ifb.cmd_valid = 0; ifb.cpuline = '0; ifb.disp_addr = '0;
    clr_a = 0; clr_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", cx_a, 0);
    check("rst_y", cy_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ready", ifa.cmd_ready, 1);
    check("rst_disp", ifa.disp_data, 0);
    @(negedge clk);
    clr_a = 1; clr_b = 1;
    mattr = 4'hF; mx = 0; my = 0;

    run_a(16'h00C0, 16'h0000, 1'b1, "init_clear");

    foreach (vt[i]) begin
      run_a(vt[i].op, vt[i].prm, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tx", i), cx_a, vt[i].ex);
      check($sformatf("vec%0d_ty", i), cy_a, vt[i].ey);
    end
    rd(0, 10'd0, d);   check("cell0_char", d, 12'h341);
    rd(0, 10'd39, d);  check("cell39_bs", d, 12'h300);
    rd(0, 10'd38, d);  check("cell38_bs", d, 12'h300);
    rd(0, 10'd1000, d); check("oob_1000", d, 0);
    rd(0, 10'd1023, d); check("oob_1023", d, 0);

    // same-cycle write and display read of one cell
    run_a(16'h00C4, 16'd2, 1'b0, "setx2");
    @(negedge clk);
    ifa.disp_addr = 10'd2;
    send_word(0, 16'h00C1);
    send_word(0, 16'h0077);
    @(posedge clk); #1;
    check("rw_same_old", ifa.disp_data, mmem[2]);
    @(posedge clk); #1;
    check("rw_same_new", ifa.disp_data, 12'h377);
    wait_idle(0, 1'b0, bc, re);
    model_cmd(16'h00C1, 16'h0077, r);
    check("rw_x", cx_a, mx);

    // scroll at bottom-right corner
    run_a(16'h00C3, 16'd30, 1'b0, "sc_sety");
    run_a(16'h00C4, 16'd100, 1'b0, "sc_setx");
    run_a(16'h00C1, 16'h0051, 1'b1, "scroll");
    check("scroll_x", cx_a, 0);
    check("scroll_y", cy_a, 24);
    rd(0, 10'(23*COLS + 39), d); check("scroll_moved", d, 12'h351);
    full_compare("scroll");

    // SCROLL_EN=0 instance wraps instead of scrolling
    do_cmd(1, 16'h00C3, 16'd30, 1'b0, bc, re);
    do_cmd(1, 16'h00C4, 16'd100, 1'b0, bc, re);
    check("b_x_clamp", cx_b, 39);
    check("b_y_clamp", cy_b, 24);
    do_cmd(1, 16'h00C1, 16'h0051, 1'b0, bc, re);
    check("b_wrap_busy", bc, 0);
    check("b_wrap_x", cx_b, 0);
    check("b_wrap_y", cy_b, 0);
    rd(1, 10'd999, d); check("b_cell999", d, 12'hF51);
    do_cmd(1, 16'h00C3, 16'd24, 1'b0, bc, re);
    do_cmd(1, 16'h00C6, 16'h0000, 1'b0, bc, re);
    check("b_nl_busy", bc, 0);
    check("b_nl_y", cy_b, 0);

    // random commands against the model
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      prm = 16'($urandom);
      if (r < 2)       op = (r == 0) ? 16'h00C0 : 16'h00C5;
      else if (r < 42) op = 16'h00C1;
      else if (r < 52) op = 16'h00C2;
      else if (r < 64) begin op = 16'h00C3; prm = 16'($urandom_range(0, 40)); end
      else if (r < 74) begin op = 16'h00C4; prm = 16'($urandom_range(0, 60)); end
      else if (r < 84) op = 16'h00C6;
      else if (r < 92) op = 16'h00C7;
      else             op = 16'($urandom);
      run_a(op, prm, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      if (k % 20 == 19) begin
        for (int j = 0; j < 8; j++) begin
          r = $urandom_range(0, N - 1);
          rd(0, AW'(r), d);
          check($sformatf("rnd%0d_rd%0d", k, r), d, mmem[r]);
        end
      end
    end
    full_compare("random");

    run_a(16'h00C0, 16'h0000, 1'b1, "clear_full");
    full_compare("clear");

    // reset ten cycles into a clear
    send_word(0, 16'h00C0);
    send_word(0, 16'h0000);
    repeat (11) @(posedge clk);
    #1;
    clr_a = 0;
    for (int i = 0; i < 10; i++) mmem[i] = {mattr, 8'h00};
    mattr = 4'hF; mx = 0; my = 0;
    #1;
    check("abort_busy_in_rst", busy_a, 0);
    @(negedge clk);
    clr_a = 1;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_ready", ifa.cmd_ready, 1);
    check("abort_x", cx_a, 0);
    check("abort_y", cy_a, 0);
    run_a(16'h1234, 16'hABCD, 1'b0, "junk_op");
    full_compare("abort");
    run_a(16'h00C1, 16'h0020, 1'b0, "attr_rst");
    rd(0, 10'd0, d); check("attr_rst_cell0", d, 12'hF20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
